sar_sequencer: RTL and testbench



---
 rtl/sar_pkg.sv | 24 ++
 rtl/sar_sequencer_if.sv | 24 ++
 rtl/sar_counter.sv | 27 ++
 rtl/sar_sequencer.sv | 130 +++++++++++++
 tb/tb_sar_sequencer.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR sequencer.
// The SETTLE state exists only when SAR_SETTLE_EN is defined.
package sar_pkg;

  localparam int unsigned DefWidth        = 8;
  localparam int unsigned DefSampleCycles = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSample,
`ifdef SAR_SETTLE_EN
    StSettle,
`endif
    StTrial,
    StDone
  } sar_state_e;

  // One counter serves both sample timing and the bit index, so size it for the larger.
  function automatic int unsigned cnt_width(input int unsigned width,
                                            input int unsigned sample_cycles);
    return $clog2((width > sample_cycles) ? width : sample_cycles);
  endfunction

endpackage

// File: rtl/sar_sequencer_if.sv
// Control/data bundle between the SAR sequencer (master) and the analog front end (slave).
interface sar_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             abort;
  logic             comp_in;
  logic             sample;
  logic             busy;
  logic [WIDTH-1:0] dac_code;
  logic [WIDTH-1:0] bit_en;
  logic [WIDTH-1:0] result;
  logic             result_valid;

  modport master (
    input  start, abort, comp_in,
    output sample, busy, dac_code, bit_en, result, result_valid
  );

  modport slave (
    output start, abort, comp_in,
    input  sample, busy, dac_code, bit_en, result, result_valid
  );
endinterface

// File: rtl/sar_counter.sv
// Loadable down-counter with terminal-count flag; times the sample phase and holds the bit index.
module sar_counter #(
  parameter int unsigned    CntW   = 3,
  parameter logic [CntW-1:0] RstVal = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  input  logic            dec,
  output logic [CntW-1:0] count,
  output logic            tc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RstVal;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - CntW'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/sar_sequencer.sv
// Successive-approximation sequencer: sample phase, MSB-first bit trials, one-cycle result strobe.
// Define SAR_SETTLE_EN to insert a SETTLE cycle ahead of every TRIAL cycle.
module sar_sequencer
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH         = DefWidth,
  parameter int unsigned SAMPLE_CYCLES = DefSampleCycles
) (
  input logic             clk,
  input logic             reset,
  sar_sequencer_if.master bus
);

  localparam int unsigned     CntW     = cnt_width(WIDTH, SAMPLE_CYCLES);
  localparam logic [CntW-1:0] KTop     = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] SampLoad = CntW'(SAMPLE_CYCLES - 1);
`ifdef SAR_SETTLE_EN
  localparam sar_state_e StBitStart = StSettle;
`else
  localparam sar_state_e StBitStart = StTrial;
`endif

  sar_state_e       state_q, state_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cnt_load, cnt_dec, cnt_tc;
  logic [CntW-1:0]  cnt_val, cnt;
  logic [WIDTH-1:0] mask;
  logic             in_bit;

  sar_counter #(
    .CntW   (CntW),
    .RstVal (KTop)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .tc       (cnt_tc)
  );

  assign mask = {{(WIDTH-1){1'b0}}, 1'b1} << cnt;

`ifdef SAR_SETTLE_EN
  assign in_bit = (state_q == StTrial) || (state_q == StSettle);
`else
  assign in_bit = (state_q == StTrial);
`endif

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    result_d = result_q;
    cnt_load = 1'b0;
    cnt_val  = KTop;
    cnt_dec  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StSample;
          code_d   = '0;
          cnt_load = 1'b1;
          cnt_val  = SampLoad;
        end
      end
      StSample: begin
        if (bus.abort) begin
          state_d  = StIdle;
          cnt_load = 1'b1;
        end else if (cnt_tc) begin
          state_d  = StBitStart;
          cnt_load = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
`ifdef SAR_SETTLE_EN
      StSettle: begin
        if (bus.abort) begin
          state_d  = StIdle;
          cnt_load = 1'b1;
        end else begin
          state_d = StTrial;
        end
      end
`endif
      StTrial: begin
        if (bus.abort) begin
          state_d  = StIdle;
          cnt_load = 1'b1;
        end else begin
          // Bit k of code_q is still clear here, so OR-ing the decision in resolves it.
          code_d = code_q | (bus.comp_in ? mask : '0);
          if (cnt_tc) begin
            state_d  = StDone;
            result_d = code_d;
            cnt_load = 1'b1;
          end else begin
            state_d = StBitStart;
            cnt_dec = 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      code_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      result_q <= result_d;
    end
  end

  assign bus.sample       = (state_q == StSample);
  assign bus.busy         = (state_q != StIdle);
  assign bus.bit_en       = in_bit ? mask : '0;
  assign bus.dac_code     = in_bit ? (code_q | mask) : ((state_q == StDone) ? code_q : '0);
  assign bus.result       = result_q;
  assign bus.result_valid = (state_q == StDone);

endmodule

// File: tb/tb_sar_sequencer.sv
// Directed bench for sar_sequencer with a behavioural comparator; SAR_SETTLE_EN selects the settle run.
module tb_sar_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] vin = 8'h00;
  logic       inv = 1'b0;
  int         tests = 0;
  int         fails = 0;

  sar_sequencer_if #(.WIDTH(8)) ifc ();

  sar_sequencer #(
    .WIDTH         (8),
    .SAMPLE_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  // inv corrupts the decision; only used in cycles where comp_in must be ignored.
  assign ifc.comp_in = inv ^ (vin >= ifc.dac_code);

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [7:0] exp_result);
    check({tag, "_sample"}, ifc.sample, 8'd0);
    check({tag, "_busy"}, ifc.busy, 8'd0);
    check({tag, "_dac"}, ifc.dac_code, 8'h00);
    check({tag, "_bit_en"}, ifc.bit_en, 8'h00);
    check({tag, "_rv"}, ifc.result_valid, 8'd0);
    check({tag, "_result"}, ifc.result, exp_result);
  endtask

  // Starts a conversion from IDLE and checks every cycle through the return to IDLE.
  task automatic convert(input logic [7:0] v, input logic [63:0] dacs, input logic [7:0] res);
    vin = v;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check("samp_sample", ifc.sample, 8'd1);
      check("samp_busy", ifc.busy, 8'd1);
      check("samp_dac", ifc.dac_code, 8'h00);
      tick();
    end
`ifdef SAR_SETTLE_EN
    for (int i = 0; i < 8; i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        inv = (ph == 0);
        check("bit_dac", ifc.dac_code, dacs[63-8*i -: 8]);
        check("bit_en", ifc.bit_en, 8'h80 >> i);
        check("bit_rv", ifc.result_valid, 8'd0);
        tick();
      end
    end
    inv = 1'b0;
`else
    for (int i = 0; i < 8; i++) begin
      check("trial_dac", ifc.dac_code, dacs[63-8*i -: 8]);
      check("trial_bit_en", ifc.bit_en, 8'h80 >> i);
      check("trial_sample", ifc.sample, 8'd0);
      check("trial_rv", ifc.result_valid, 8'd0);
      tick();
    end
`endif
    check("done_rv", ifc.result_valid, 8'd1);
    check("done_result", ifc.result, res);
    check("done_dac", ifc.dac_code, res);
    check("done_busy", ifc.busy, 8'd1);
    tick();
    check_idle("post", res);
  endtask

  initial begin
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    tick();
    tick();
    check_idle("reset", 8'h00);
    reset = 1'b0;
    tick();
    check_idle("idle", 8'h00);

`ifdef SAR_SETTLE_EN
    convert(8'h5A, 64'h80_40_60_50_58_5C_5A_5B, 8'h5A);
`else
    convert(8'hA5, 64'h80_C0_A0_B0_A8_A4_A6_A5, 8'hA5);
    convert(8'h00, 64'h80_40_20_10_08_04_02_01, 8'h00);
    convert(8'hFF, 64'h80_C0_E0_F0_F8_FC_FE_FF, 8'hFF);

    // start held high: DONE ignores it, IDLE re-arms, 12-cycle period.
    vin = 8'hA5;
    ifc.start = 1'b1;
    tick();
    for (int c = 1; c <= 36; c++) begin
      check("rpt_rv", ifc.result_valid, 8'((c % 12) == 11));
      check("rpt_busy", ifc.busy, 8'((c % 12) != 0));
      if (c == 36) ifc.start = 1'b0;
      tick();
    end
    check_idle("rpt_end", 8'hA5);

    // Abort during the 4th trial; result must keep the previous code.
    vin = 8'h3C;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    check("abort_pre_bit_en", ifc.bit_en, 8'h10);
    ifc.abort = 1'b1;
    tick();
    ifc.abort = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check_idle("abort", 8'hA5);
      tick();
    end

    // Asynchronous reset mid-trial.
    vin = 8'hFF;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    check("rst_pre_busy", ifc.busy, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    check_idle("async_rst", 8'h00);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_idle("rst_release", 8'h00);
    convert(8'h3C, 64'h80_40_20_30_38_3C_3E_3D, 8'h3C);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
